fifo_rd_arbiter: RTL



---
 rtl/fifo_rd_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/fifo_rd_arbiter.sv
// Round-robin owner of an async FIFO's read port, living in the r_clk domain.
// Grants bursts of up to BURST_LEN accepted reads and steers rd_valid to the reading owner.
module fifo_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4,
    parameter int EN_REG    = 1,
    parameter int DATA_LAT  = 0
) (
    input  logic               r_clk,
    input  logic               rrst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               r_empty,
    output logic               r_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rd_valid,
    output logic               busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            vec[i] = (int'(idx) == i);
        end
        return vec;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [NUM_REQ-1:0] gnt_r;
    logic [IW-1:0]      owner_r;
    logic [IW-1:0]      last_r;
    logic               busy_r;
    logic [CW-1:0]      issued_cnt_r;
    logic [CW-1:0]      acc_cnt_r;

    logic               found_s;
    logic [IW-1:0]      pick_s;
    logic [IW-1:0]      cand_s;
    logic               req_own_s;
    logic               r_en_s;
    logic               acc_s;
    logic               rej_s;
    logic [IW-1:0]      acc_own_s;
    logic               pend_any_s;
    logic               acc_hit_s;
    logic               start_s;
    logic               stop_s;
    logic [NUM_REQ-1:0] acc_vec_s;

    assign req_own_s = |(req & gnt_r);
    assign r_en_s    = (state_r == BURST) & req_own_s & ~r_empty & (issued_cnt_r < BURST_MAX);
    assign acc_hit_s = ({1'b0, acc_cnt_r} + {{CW{1'b0}}, acc_s}) >= {1'b0, BURST_MAX};
    assign start_s   = (state_r == IDLE) & (state_next_s == BURST);
    assign stop_s    = (state_r == DRAIN) & (state_next_s == IDLE);

    // Rotating-priority search beginning just after the previous winner
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = last_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand_s == LAST_INIT) begin
                cand_s = '0;
            end else begin
                cand_s = cand_s + IW'(1);
            end
            if (!found_s && (|(req & onehot_f(cand_s)))) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state decode; DRAIN holds the grant until every issued read is resolved
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_next_s = BURST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BURST: begin
                if (acc_hit_s || !req_own_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = BURST;
                end
            end
            DRAIN: begin
                if (!pend_any_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, grant, owner and round-robin pointer registers
    always_ff @(posedge r_clk) begin
        if (!rrst_n) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            owner_r <= '0;
            last_r  <= LAST_INIT;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            if (start_s) begin
                gnt_r   <= onehot_f(pick_s);
                owner_r <= pick_s;
                last_r  <= pick_s;
            end else if (stop_s) begin
                gnt_r <= '0;
            end else begin
                gnt_r <= gnt_r;
            end
        end
    end

    // Burst counters: a rejected read gives its issue slot back
    always_ff @(posedge r_clk) begin
        if (!rrst_n) begin
            issued_cnt_r <= '0;
            acc_cnt_r    <= '0;
        end else if (start_s) begin
            issued_cnt_r <= '0;
            acc_cnt_r    <= '0;
        end else begin
            issued_cnt_r <= issued_cnt_r + CW'(r_en_s) - CW'(rej_s);
            acc_cnt_r    <= acc_cnt_r + CW'(acc_s);
        end
    end

    generate
        if (EN_REG == 0) begin : g_comb_acc
            // r_en already requires a non-empty FIFO, so every issue is accepted on the spot
            assign acc_s      = r_en_s;
            assign rej_s      = 1'b0;
            assign acc_own_s  = owner_r;
            assign pend_any_s = 1'b0;
        end else begin : g_reg_acc
            logic [EN_REG-1:0] pend_r;
            logic [IW-1:0]     pown_r [EN_REG];

            // Carry each issued read and its owner up to the FIFO's accept decision
            always_ff @(posedge r_clk) begin
                if (!rrst_n) begin
                    pend_r <= '0;
                    for (int i = 0; i < EN_REG; i++) begin
                        pown_r[i] <= '0;
                    end
                end else begin
                    pend_r[0] <= r_en_s;
                    pown_r[0] <= owner_r;
                    for (int i = 1; i < EN_REG; i++) begin
                        pend_r[i] <= pend_r[i-1];
                        pown_r[i] <= pown_r[i-1];
                    end
                end
            end

            assign acc_s      = pend_r[EN_REG-1] & ~r_empty;
            assign rej_s      = pend_r[EN_REG-1] & r_empty;
            assign acc_own_s  = pown_r[EN_REG-1];
            assign pend_any_s = |pend_r;
        end
    endgenerate

    assign acc_vec_s = acc_s ? onehot_f(acc_own_s) : {NUM_REQ{1'b0}};

    generate
        if (DATA_LAT == 0) begin : g_valid_now
            assign rd_valid = acc_vec_s;
        end else begin : g_valid_pipe
            logic [NUM_REQ-1:0] vpipe_r [DATA_LAT];

            // Delay the accepting owner to line up with the FIFO's read data
            always_ff @(posedge r_clk) begin
                if (!rrst_n) begin
                    for (int i = 0; i < DATA_LAT; i++) begin
                        vpipe_r[i] <= '0;
                    end
                end else begin
                    vpipe_r[0] <= acc_vec_s;
                    for (int i = 1; i < DATA_LAT; i++) begin
                        vpipe_r[i] <= vpipe_r[i-1];
                    end
                end
            end

            assign rd_valid = vpipe_r[DATA_LAT-1];
        end
    endgenerate

    assign r_en = r_en_s;
    assign gnt  = gnt_r;
    assign busy = busy_r;

endmodule
